rriot_timer: RTL and testbench
==============================

# rriot_timer

Programmable interval timer for the 6530 RRIOT core. It shares the chip-internal register bus with the port I/O block: same enable, we_n, address, DI, DO and OE strobes, with the two blocks' DO/OE outputs OR-merged by the bus mux. It provides an 8-bit down-counter with a selectable prescaler (÷1, ÷8, ÷64, ÷1024), a timeout flag, and an active-low interrupt output. The top level routes that output to the PB7/IRQ pin logic of the port I/O block.

## Interface
Parameters:
- none (prescale ratios fixed at 1/8/64/1024)

Ports:
- clk  in  1  core clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  register-select strobe for this cycle (chip select and RS decode done upstream)
- we_n  in  1  0 = write, 1 = read
- A  in  4  register address; A[2]=1 selects timer space, A[3] = IRQ enable, A[1:0] = prescale select on writes, A[0] = timer/flag select on reads
- DI  in  8  write data
- DO  out  8  read data, registered; 8'h00 whenever OE=0
- OE  out  1  high for exactly the cycle DO is valid
- IRQ_n  out  1  low when flag & irq_en

## Operation
State:
- count[7:0]
- psel[1:0]
- irq_en
- flag
- armed
- fast (post-timeout ÷1 mode)
- prescaler counter pre[9:0]

Accesses (only when enable=1 and A[2]=1; A[2]=0 is ignored and gives OE=0):
- Write (we_n=0):
  - count <= DI; psel <= A[1:0]; irq_en <= A[3]
  - flag <= 0; fast <= 0; pre <= 0; armed <= 1
- Read timer (we_n=1, A[0]=0):
  - DO <= count (pre-edge value), OE <= 1
  - irq_en <= A[3]; flag <= 0; fast <= 0
  - pre is not reset.
- Read flag (we_n=1, A[0]=1):
  - DO <= {flag, 7'b0}, OE <= 1
  - No side effects.

Counting (only while armed=1):
- Divisor D = 1 when fast=1; otherwise D = 1, 8, 64 or 1024 for psel 00, 01, 10, 11.
- pre increments each cycle. When pre == D-1, a tick fires and pre <= 0.
- Tick with count != 0: count <= count-1.
- Tick with count == 0: count <= 8'hFF, flag <= 1, fast <= 1.
- In fast mode the counter keeps decrementing every cycle and wraps FF→…→00→FF. flag stays set, with no further side effects.

Priority for simultaneous events:
- A write overrides the tick in the same cycle.
- A timeout setting flag beats a read-timer clear in the same cycle: flag ends at 1 and fast ends at 1.
- A read-flag access coincident with a flag set returns the old value (0).

Output:
- IRQ_n = ~(flag & irq_en), combinational from registers.

## Timing
Reset values (rst high at an edge):
- count=0, psel=00, irq_en=0, flag=0, armed=0, fast=0, pre=0
- DO=8'h00, OE=0, IRQ_n=1
- rst overrides any access in the same cycle.
- The timer holds after reset until the first write.

Latency and ticks:
- Read data appears on DO/OE the cycle after the access edge, for one cycle only.
- Write at edge N:
  - count=DI from N.
  - First decrement at edge N+D, then one decrement every D cycles.
  - Timeout (count 00→FF, flag set) at edge N+(DI+1)·D.
  - Afterwards one decrement per cycle.
- IRQ_n falls in the same cycle flag becomes visible, provided irq_en=1.
- irq_en change via write or read takes effect on IRQ_n the cycle after the access edge.
- Reset mid-count returns to the idle state; no pending tick survives.

## Test plan
- Reset then idle 2000 cycles → count stays 00, flag=0, IRQ_n=1; read-flag returns 8'h00 with OE=1 for one cycle.
- Write DI=03, A=4'b1101 (÷8, IRQ on) at edge N → count sequence:
  - 03 at N, 02 at N+8, 01 at N+16, 00 at N+24
  - FF with flag=1 and IRQ_n=0 at N+32
  - FE at N+33
- Same as above with A=4'b0101 (IRQ off) → flag=1 at N+32 but IRQ_n stays 1; read-flag returns 8'h80.
- After a timeout with irq_en=1, read timer with A=4'b1100 → DO = current count; flag=0 and IRQ_n=1 next cycle; decrements resume at ÷1024 spacing.
- Write DI=00, ÷1, IRQ on → timeout on the next edge (count FF, flag=1). Issue a read-timer in the exact timeout cycle → flag remains 1.
- Write during a running ÷64 count at pre=40 → count reloads, pre restarts, next tick exactly 64 cycles later; concurrent accesses with A[2]=0 give OE=0, DO=00.

Source files
------------

// File: rtl/rriot_timer_if.sv
// Register-bus bundle shared by the RRIOT timer and port I/O blocks.
// The master side issues strobes; the slave side returns read data and the interrupt.
interface rriot_timer_if;
    logic       enable;
    logic       we_n;
    logic [3:0] A;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       OE;
    logic       IRQ_n;

    modport master (
        output enable, we_n, A, DI,
        input  DO, OE, IRQ_n
    );

    modport slave (
        input  enable, we_n, A, DI,
        output DO, OE, IRQ_n
    );
endinterface

// File: rtl/rriot_timer.sv
// 6530 RRIOT interval timer: 8-bit down-counter behind a 1/8/64/1024 prescaler,
// with a timeout flag, post-timeout /1 fast mode and an active-low interrupt.
module rriot_timer (
    input  logic          clk,
    input  logic          rst,
    rriot_timer_if.slave  bus
);

    logic [7:0] count;
    logic [1:0] psel;
    logic       irq_en;
    logic       flag;
    logic       armed;
    logic       fast;
    logic [9:0] pre;
    logic [7:0] rdata;
    logic       rvalid;

    logic [9:0] div_m1;
    logic       tick;
    logic       timeout;
    logic       sel;
    logic       wr;
    logic       rd_timer;
    logic       rd_flag;

    always_comb begin
        div_m1 = 10'd0;
        if (!fast) begin
            case (psel)
                2'b00:   div_m1 = 10'd0;
                2'b01:   div_m1 = 10'd7;
                2'b10:   div_m1 = 10'd63;
                default: div_m1 = 10'd1023;
            endcase
        end
        tick     = armed && (pre == div_m1);
        // Only the first underflow is a timeout; fast-mode wraps have no side effects.
        timeout  = tick && (count == 8'h00) && !fast;
        sel      = bus.enable && bus.A[2];
        wr       = sel && !bus.we_n;
        rd_timer = sel && bus.we_n && !bus.A[0];
        rd_flag  = sel && bus.we_n && bus.A[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 8'h00;
            psel   <= 2'b00;
            irq_en <= 1'b0;
            flag   <= 1'b0;
            armed  <= 1'b0;
            fast   <= 1'b0;
            pre    <= 10'd0;
            rdata  <= 8'h00;
            rvalid <= 1'b0;
        end else begin
            rdata  <= 8'h00;
            rvalid <= 1'b0;
            if (wr) begin
                count  <= bus.DI;
                psel   <= bus.A[1:0];
                irq_en <= bus.A[3];
                flag   <= 1'b0;
                fast   <= 1'b0;
                pre    <= 10'd0;
                armed  <= 1'b1;
            end else begin
                if (rd_timer) begin
                    rdata  <= count;
                    rvalid <= 1'b1;
                    irq_en <= bus.A[3];
                    flag   <= 1'b0;
                    fast   <= 1'b0;
                end
                if (rd_flag) begin
                    rdata  <= {flag, 7'b0};
                    rvalid <= 1'b1;
                end
                if (armed) begin
                    if (tick) begin
                        pre   <= 10'd0;
                        count <= count - 8'd1;
                    end else begin
                        pre <= pre + 10'd1;
                    end
                end
                // Placed after the read clear so a coincident timeout wins.
                if (timeout) begin
                    flag <= 1'b1;
                    fast <= 1'b1;
                end
            end
        end
    end

    assign bus.DO    = rdata;
    assign bus.OE    = rvalid;
    assign bus.IRQ_n = ~(flag & irq_en);

endmodule

// File: tb/tb_rriot_timer.sv
// Directed bench for rriot_timer: hand-computed count/flag/IRQ timelines.
module tb_rriot_timer;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    rriot_timer_if bus ();

    rriot_timer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    // One-cycle bus access; returns 1 time unit after its edge.
    task automatic access(input logic wn, input logic [3:0] a, input logic [7:0] d);
        bus.enable = 1'b1;
        bus.we_n   = wn;
        bus.A      = a;
        bus.DI     = d;
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
        bus.we_n   = 1'b1;
        bus.A      = 4'h0;
        bus.DI     = 8'h00;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        bus.enable = 1'b0;
        bus.we_n   = 1'b1;
        bus.A      = 4'h0;
        bus.DI     = 8'h00;
        step(2);
        rst = 1'b0;

        // Reset state and long idle
        check("rst_count", dut.count, 8'h00);
        check("rst_do", bus.DO, 8'h00);
        check("rst_oe", bus.OE, 1'b0);
        check("rst_irq", bus.IRQ_n, 1'b1);
        step(2000);
        check("idle_count", dut.count, 8'h00);
        check("idle_flag", dut.flag, 1'b0);
        check("idle_irq", bus.IRQ_n, 1'b1);
        access(1'b1, 4'b0101, 8'h00);
        check("idle_rdflag_oe", bus.OE, 1'b1);
        check("idle_rdflag_do", bus.DO, 8'h00);
        step(1);
        check("idle_rdflag_oe_drop", bus.OE, 1'b0);

        // /8 with IRQ on, DI=03
        access(1'b0, 4'b1101, 8'h03);
        check("d8_n0", dut.count, 8'h03);
        step(7);
        check("d8_n7", dut.count, 8'h03);
        step(1);
        check("d8_n8", dut.count, 8'h02);
        step(8);
        check("d8_n16", dut.count, 8'h01);
        step(8);
        check("d8_n24", dut.count, 8'h00);
        step(7);
        check("d8_n31_count", dut.count, 8'h00);
        check("d8_n31_irq", bus.IRQ_n, 1'b1);
        step(1);
        check("d8_n32_count", dut.count, 8'hFF);
        check("d8_n32_flag", dut.flag, 1'b1);
        check("d8_n32_irq", bus.IRQ_n, 1'b0);
        step(1);
        check("d8_n33_count", dut.count, 8'hFE);

        // /8 with IRQ off: flag sets, IRQ_n stays high
        access(1'b0, 4'b0101, 8'h03);
        check("noirq_n0_flag", dut.flag, 1'b0);
        check("noirq_n0_irq", bus.IRQ_n, 1'b1);
        step(32);
        check("noirq_n32_count", dut.count, 8'hFF);
        check("noirq_n32_flag", dut.flag, 1'b1);
        check("noirq_n32_irq", bus.IRQ_n, 1'b1);
        access(1'b1, 4'b0101, 8'h00);
        check("noirq_rdflag_oe", bus.OE, 1'b1);
        check("noirq_rdflag_do", bus.DO, 8'h80);
        check("noirq_rdflag_keep", dut.flag, 1'b1);
        step(1);
        check("noirq_oe_drop", bus.OE, 1'b0);
        check("noirq_do_drop", bus.DO, 8'h00);

        // /1024 timeout, then read-timer clears flag and restores /1024 spacing
        access(1'b0, 4'b1111, 8'h00);
        step(1023);
        check("d1024_pre_count", dut.count, 8'h00);
        check("d1024_pre_flag", dut.flag, 1'b0);
        step(1);
        check("d1024_to_count", dut.count, 8'hFF);
        check("d1024_to_irq", bus.IRQ_n, 1'b0);
        step(1);
        check("d1024_fast", dut.count, 8'hFE);
        access(1'b1, 4'b1100, 8'h00);
        check("rdtim_do", bus.DO, 8'hFE);
        check("rdtim_oe", bus.OE, 1'b1);
        check("rdtim_flag", dut.flag, 1'b0);
        check("rdtim_irq", bus.IRQ_n, 1'b1);
        check("rdtim_count", dut.count, 8'hFD);
        step(1);
        check("rdtim_oe_drop", bus.OE, 1'b0);
        step(1022);
        check("rdtim_hold", dut.count, 8'hFD);
        step(1);
        check("rdtim_tick", dut.count, 8'hFC);

        // /1 with DI=00: timeout on the next edge beats a coincident read-timer
        access(1'b0, 4'b1100, 8'h00);
        check("d1_n0_count", dut.count, 8'h00);
        access(1'b1, 4'b1100, 8'h00);
        check("race_do", bus.DO, 8'h00);
        check("race_oe", bus.OE, 1'b1);
        check("race_count", dut.count, 8'hFF);
        check("race_flag", dut.flag, 1'b1);
        check("race_irq", bus.IRQ_n, 1'b0);
        step(1);
        check("race_fast", dut.count, 8'hFE);
        check("race_flag_hold", dut.flag, 1'b1);

        // Write during /64 count at pre=40 restarts the prescaler
        access(1'b0, 4'b0110, 8'h10);
        step(40);
        check("d64_pre40", dut.pre, 10'd40);
        check("d64_pre40_count", dut.count, 8'h10);
        access(1'b0, 4'b0110, 8'h05);
        check("d64_reload", dut.count, 8'h05);
        check("d64_pre_clr", dut.pre, 10'd0);
        access(1'b1, 4'b0001, 8'h00);
        check("a2lo_rd_oe", bus.OE, 1'b0);
        check("a2lo_rd_do", bus.DO, 8'h00);
        access(1'b0, 4'b0011, 8'hAA);
        check("a2lo_wr_count", dut.count, 8'h05);
        check("a2lo_wr_oe", bus.OE, 1'b0);
        step(61);
        check("d64_n63", dut.count, 8'h05);
        step(1);
        check("d64_n64", dut.count, 8'h04);

        // Reset mid-count returns to idle
        step(10);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("midrst_count", dut.count, 8'h00);
        check("midrst_flag", dut.flag, 1'b0);
        check("midrst_irq", bus.IRQ_n, 1'b1);
        check("midrst_oe", bus.OE, 1'b0);
        step(100);
        check("midrst_hold", dut.count, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
